// File: rtl/fabric_pkg.sv
// rtl/fabric_pkg.sv - shared routing-fabric types and default select geometry
//
// Contents:
//   cfg_state_e              configuration loader FSM encoding (IDLE/LOAD/CHECK)
//   DEFAULT_NUM_INPUTS       legal inputs per routing block
//   DEFAULT_NUM_INPUTS_LOG_2 select field width; one bit wider than needed so
//                            out-of-range selects can be expressed and rejected
package fabric_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2
    } cfg_state_e;

    localparam int DEFAULT_NUM_INPUTS       = 8;
    localparam int DEFAULT_NUM_INPUTS_LOG_2 = 4;

endpackage

// File: rtl/select_range_check.sv
// rtl/select_range_check.sv - combinational legality check of one select value
//
// Parameters:
//   NUM_INPUTS        number of legal inputs; legal selects are 0..NUM_INPUTS-1
//   NUM_INPUTS_LOG_2  select field width
// Ports:
//   data      in   select value under test
//   in_range  out  1 when data < NUM_INPUTS
module select_range_check #(
    parameter int NUM_INPUTS       = 8,
    parameter int NUM_INPUTS_LOG_2 = 4
) (
    input  logic [NUM_INPUTS_LOG_2-1:0] data,
    output logic                        in_range
);

    // One extra bit so NUM_INPUTS == 2**width still compares correctly.
    localparam logic [NUM_INPUTS_LOG_2:0] LIMIT = (NUM_INPUTS_LOG_2 + 1)'(NUM_INPUTS);

    assign in_range = ({1'b0, data} < LIMIT);

endmodule

// File: rtl/routing_config_loader.sv
// rtl/routing_config_loader.sv - framed, range-checked, double-buffered select loader
//
// Parameters:
//   NUM_BLOCKS        routing blocks driven, one select field each
//   NUM_INPUTS        legal inputs per routing block
//   NUM_INPUTS_LOG_2  select field width (SW)
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous, active-high
//   cfgStart      in   begin (or restart) a frame
//   cfgValid      in   cfgData beat valid
//   cfgData       in   select value for the next block in order
//   cfgReady      out  loader accepts a beat this cycle
//   selectOut     out  active selects, block k at [k*SW +: SW]
//   routeInvalid  in   configInvalid from each routing block
//   cfgDone       out  one-cycle pulse on a successful commit
//   cfgError      out  last frame rejected; sticky until next cfgStart
//   cfgFault      out  a routing block reported invalid since last commit
module routing_config_loader
    import fabric_pkg::*;
#(
    parameter int NUM_BLOCKS       = 4,
    parameter int NUM_INPUTS       = DEFAULT_NUM_INPUTS,
    parameter int NUM_INPUTS_LOG_2 = DEFAULT_NUM_INPUTS_LOG_2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cfgStart,
    input  logic                                   cfgValid,
    input  logic [NUM_INPUTS_LOG_2-1:0]            cfgData,
    output logic                                   cfgReady,
    output logic [NUM_BLOCKS*NUM_INPUTS_LOG_2-1:0] selectOut,
    input  logic [NUM_BLOCKS-1:0]                  routeInvalid,
    output logic                                   cfgDone,
    output logic                                   cfgError,
    output logic                                   cfgFault
);

    localparam int SW = NUM_INPUTS_LOG_2;
    localparam int CW = $clog2(NUM_BLOCKS) + 1;
    localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BLOCKS - 1);

    cfg_state_e state_q;
    cfg_state_e state_d;

    logic [CW-1:0]                   cnt_q;
    logic [NUM_BLOCKS-1:0][SW-1:0]   shadow_q;
    logic [NUM_BLOCKS*SW-1:0]        select_q;
    logic                            bad_q;
    logic                            ready_q;
    logic                            done_q;
    logic                            error_q;
    logic                            fault_q;

    logic data_in_range;
    logic beat_accept;
    logic last_beat;

    select_range_check #(
        .NUM_INPUTS       (NUM_INPUTS),
        .NUM_INPUTS_LOG_2 (SW)
    ) u_range_check (
        .data     (cfgData),
        .in_range (data_in_range)
    );

    // ready_q is only ever high in LOAD; a restart pulse drops any beat
    // presented in the same cycle.
    assign beat_accept = cfgValid && ready_q && !cfgStart;
    assign last_beat   = beat_accept && (cnt_q == LAST_BEAT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cfgStart) state_d = LOAD;
            LOAD:    if (last_beat) state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            select_q <= '0;
            bad_q    <= 1'b0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == LOAD);
            done_q  <= 1'b0;

            // Set first so a same-cycle successful commit below overrides it:
            // the fault belongs to the configuration being replaced.
            if (|routeInvalid) fault_q <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (cfgStart) begin
                        cnt_q    <= '0;
                        shadow_q <= '0;
                        bad_q    <= 1'b0;
                        error_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfgStart) begin
                        cnt_q    <= '0;
                        shadow_q <= '0;
                        bad_q    <= 1'b0;
                    end else if (beat_accept) begin
                        shadow_q[cnt_q[IW-1:0]] <= cfgData;
                        cnt_q                   <= cnt_q + CW'(1);
                        if (!data_in_range) bad_q <= 1'b1;
                    end
                end
                CHECK: begin
                    if (!bad_q) begin
                        select_q <= shadow_q;
                        done_q   <= 1'b1;
                        fault_q  <= 1'b0;
                    end else begin
                        error_q  <= 1'b1;
                        shadow_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfgReady  = ready_q;
    assign selectOut = select_q;
    assign cfgDone   = done_q;
    assign cfgError  = error_q;
    assign cfgFault  = fault_q;

endmodule

// File: tb/tb_routing_config_loader.sv
// tb/tb_routing_config_loader.sv - self-checking bench for routing_config_loader
module tb_routing_config_loader;

    typedef logic [3:0] frame_t [4];

    logic        clk = 1'b0;
    logic        reset;
    logic        cfgStart;
    logic        cfgValid;
    logic [3:0]  cfgData;
    logic        cfgReady;
    logic [15:0] selectOut;
    logic [3:0]  routeInvalid;
    logic        cfgDone;
    logic        cfgError;
    logic        cfgFault;

    int passed = 0;
    int total  = 0;

    logic [15:0] model_select;
    logic        model_fault;

    always #5 clk = ~clk;

    routing_config_loader #(
        .NUM_BLOCKS       (4),
        .NUM_INPUTS       (8),
        .NUM_INPUTS_LOG_2 (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfgStart     (cfgStart),
        .cfgValid     (cfgValid),
        .cfgData      (cfgData),
        .cfgReady     (cfgReady),
        .selectOut    (selectOut),
        .routeInvalid (routeInvalid),
        .cfgDone      (cfgDone),
        .cfgError     (cfgError),
        .cfgFault     (cfgFault)
    );

    function automatic logic [15:0] pack_frame(input frame_t v);
        logic [15:0] r;
        r = 16'h0;
        for (int k = 0; k < 4; k++) r = r + (16'(v[k]) << (4 * k));
        return r;
    endfunction

    // Drives one frame starting from the current negedge. Beats are counted as
    // accepted whenever valid is presented while loading; the commit must land
    // two cycles after the last beat, and only when every value is below 8.
    task automatic run_frame(input frame_t v, input int gap_mode, input bit fault_at_commit, input string name);
        bit          ok;
        int          idx;
        int          post;
        int          done_cycle;
        int          done_count;
        int          last_drive;
        int          ready_bad;
        logic [15:0] exp_sel;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) if (v[k] >= 4'd8) ok = 1'b0;
        exp_sel = ok ? pack_frame(v) : model_select;

        cfgStart = 1'b1;
        @(negedge clk);
        cfgStart = 1'b0;
        total++;
        if (cfgError !== 1'b0) $display("FAIL %s err_clear_on_start: got %b want 0", name, cfgError);
        else passed++;

        idx = 0; post = 0; done_cycle = -1; done_count = 0; last_drive = 0; ready_bad = 0;
        for (int cyc = 1; cyc < 100; cyc++) begin
            if (cfgDone === 1'b1) begin
                done_count++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (cfgReady !== (idx < 4)) ready_bad++;
            if (idx == 4) post++;
            if (post > 4) break;
            routeInvalid = (fault_at_commit && idx == 4 && post == 1) ? 4'b0010 : 4'b0000;
            if (idx < 4) begin
                case (gap_mode)
                    0:       cfgValid = 1'b1;
                    1:       cfgValid = (cyc % 2 == 1);
                    default: cfgValid = 1'($urandom_range(0, 1));
                endcase
                cfgData = cfgValid ? v[idx] : 4'($urandom);
            end else begin
                cfgValid = 1'b0;
            end
            @(posedge clk);
            if (cfgValid && idx < 4) begin
                idx++;
                last_drive = cyc;
            end
            @(negedge clk);
        end
        cfgValid = 1'b0;
        routeInvalid = 4'b0000;

        total++;
        if (post <= 4) $display("FAIL %s timeout: beats=%0d want 4", name, idx);
        else passed++;
        total++;
        if (ready_bad != 0) $display("FAIL %s ready: %0d wrong cycles want 0", name, ready_bad);
        else passed++;
        total++;
        if (done_count != (ok ? 1 : 0)) $display("FAIL %s done_count: got %0d want %0d", name, done_count, ok ? 1 : 0);
        else passed++;
        if (ok) begin
            total++;
            if (done_cycle != last_drive + 2) $display("FAIL %s done_cycle: got %0d want %0d", name, done_cycle, last_drive + 2);
            else passed++;
            model_fault = 1'b0;
        end
        total++;
        if (selectOut !== exp_sel) $display("FAIL %s selectOut: got %h want %h", name, selectOut, exp_sel);
        else passed++;
        total++;
        if (cfgError !== !ok) $display("FAIL %s cfgError: got %b want %b", name, cfgError, !ok);
        else passed++;
        total++;
        if (cfgFault !== model_fault) $display("FAIL %s cfgFault: got %b want %b", name, cfgFault, model_fault);
        else passed++;
        model_select = exp_sel;
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (selectOut !== 16'h0) $display("FAIL %s selectOut: got %h want 0000", name, selectOut);
        else passed++;
        total++;
        if (cfgReady !== 1'b0) $display("FAIL %s cfgReady: got %b want 0", name, cfgReady);
        else passed++;
        total++;
        if (cfgDone !== 1'b0) $display("FAIL %s cfgDone: got %b want 0", name, cfgDone);
        else passed++;
        total++;
        if (cfgError !== 1'b0) $display("FAIL %s cfgError: got %b want 0", name, cfgError);
        else passed++;
        total++;
        if (cfgFault !== 1'b0) $display("FAIL %s cfgFault: got %b want 0", name, cfgFault);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; cfgStart = 1'b0; cfgValid = 1'b0; cfgData = 4'h0; routeInvalid = 4'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        model_select = 16'h0;
        model_fault  = 1'b0;
        @(negedge clk);
        total++;
        if (cfgReady !== 1'b0) $display("FAIL reset_idle_ready: got %b want 0", cfgReady);
        else passed++;
    endtask

    task automatic test_basic();
        run_frame('{4'd3, 4'd0, 4'd7, 4'd5}, 0, 1'b0, "basic");
        total++;
        if (selectOut !== 16'h5703) $display("FAIL basic_value: got %h want 5703", selectOut);
        else passed++;
    endtask

    task automatic test_reject();
        run_frame('{4'd1, 4'd9, 4'd2, 4'd2}, 0, 1'b0, "reject");
        repeat (5) @(negedge clk);
        total++;
        if (cfgError !== 1'b1) $display("FAIL reject_sticky: got %b want 1", cfgError);
        else passed++;
        total++;
        if (selectOut !== 16'h5703) $display("FAIL reject_keep: got %h want 5703", selectOut);
        else passed++;
    endtask

    task automatic test_gapped();
        run_frame('{4'd6, 4'd6, 4'd6, 4'd6}, 1, 1'b0, "gapped");
    endtask

    task automatic test_restart();
        cfgStart = 1'b1;
        @(negedge clk);
        cfgStart = 1'b0;
        for (int b = 0; b < 2; b++) begin
            cfgValid = 1'b1; cfgData = 4'd4;
            @(negedge clk);
        end
        // A beat coincides with the restart pulse and must be dropped.
        cfgValid = 1'b1; cfgData = 4'd4;
        run_frame('{4'd2, 4'd1, 4'd0, 4'd3}, 0, 1'b0, "restart");
        total++;
        if (selectOut !== 16'h3012) $display("FAIL restart_value: got %h want 3012", selectOut);
        else passed++;
    endtask

    task automatic test_fault();
        routeInvalid = 4'b0100;
        @(negedge clk);
        routeInvalid = 4'b0000;
        model_fault = 1'b1;
        total++;
        if (cfgFault !== 1'b1) $display("FAIL fault_set: got %b want 1", cfgFault);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (cfgFault !== 1'b1) $display("FAIL fault_hold: got %b want 1", cfgFault);
        else passed++;
        run_frame('{4'd0, 4'd9, 4'd1, 4'd1}, 0, 1'b0, "fault_rejected_keeps");
        run_frame('{4'd7, 4'd2, 4'd4, 4'd1}, 0, 1'b0, "fault_commit_clears");
        routeInvalid = 4'b1000;
        @(negedge clk);
        routeInvalid = 4'b0000;
        model_fault = 1'b1;
        run_frame('{4'd5, 4'd5, 4'd3, 4'd0}, 2, 1'b1, "fault_same_cycle");
    endtask

    task automatic test_reset_midframe();
        cfgStart = 1'b1;
        @(negedge clk);
        cfgStart = 1'b0;
        for (int b = 0; b < 2; b++) begin
            cfgValid = 1'b1; cfgData = 4'd2;
            @(negedge clk);
        end
        routeInvalid = 4'b0001;
        @(negedge clk);
        routeInvalid = 4'b0000;
        reset = 1'b1; cfgValid = 1'b1; cfgData = 4'd2;
        @(negedge clk);
        reset = 1'b0; cfgValid = 1'b0;
        check_reset_outputs("midframe_reset");
        model_select = 16'h0;
        model_fault  = 1'b0;
        run_frame('{4'd1, 4'd1, 4'd1, 4'd1}, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        frame_t v;
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 4; k++)
                v[k] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            run_frame(v, int'($urandom_range(0, 2)), 1'b0, "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_gapped();
        test_restart();
        test_fault();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
